// File: rtl/flippy_pkg.sv
// Constants shared by the column scheduler, Column and Display blocks.
// Also holds the letter LFSR step function.
package flippy_pkg;

  localparam int unsigned NUM_COLS  = 3;
  localparam int unsigned LETTER_W  = 8;
  localparam int unsigned YPOS_W    = 5;
  localparam int unsigned COL_IDX_W = $clog2(NUM_COLS);

  localparam logic [LETTER_W-1:0] LFSR_SEED = 8'h01;
  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 as a bit mask.
  localparam logic [LETTER_W-1:0] LFSR_TAPS = 8'hB8;

  function automatic logic [LETTER_W-1:0] lfsr_next(input logic [LETTER_W-1:0] s);
    return {s[LETTER_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/letter_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that supplies nonzero letter codes.
module letter_lfsr
  import flippy_pkg::*;
(
  input  logic                clock,
  input  logic                reset_signal,
  output logic [LETTER_W-1:0] value
);

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      value <= LFSR_SEED;
    end else begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/column_scheduler.sv
// Generates the shared fall tick, paces spawn requests and grants them
// round-robin to idle columns, tagging each spawn with an LFSR letter.
module column_scheduler
  import flippy_pkg::*;
#(
  parameter int unsigned TICK_BASE = 25_000_000,
  parameter int unsigned TICK_MIN  = 2_500_000,
  parameter int unsigned TICK_STEP = 500_000,
  parameter int unsigned SPAWN_GAP = 4
) (
  input  logic                clock,
  input  logic                reset_signal,
  input  logic                enable,
  input  logic [7:0]          score,
  input  logic [NUM_COLS-1:0] col_active,
  output logic                fall_tick,
  output logic [NUM_COLS-1:0] spawn,
  output logic [LETTER_W-1:0] letter_out
);

  logic [31:0]          cnt;
  logic [31:0]          period_q;
  logic [31:0]          gap_cnt;
  logic                 pending;
  logic [COL_IDX_W-1:0] last_grant;

  logic [31:0]          product;
  logic [31:0]          raw;
  logic [31:0]          period_calc;
  logic                 wrap;
  logic                 expiry;
  logic                 grant_found;
  logic [COL_IDX_W-1:0] grant_idx;
  logic [COL_IDX_W-1:0] cand_idx;
  logic [31:0]          cand;
  logic [LETTER_W-1:0]  lfsr_value;

  letter_lfsr u_letter_lfsr (
    .clock        (clock),
    .reset_signal (reset_signal),
    .value        (lfsr_value)
  );

  // Product is checked separately so a large level cannot wrap the subtraction.
  always_comb begin
    product     = 32'(TICK_STEP) * {27'd0, score[7:3]};
    raw         = 32'(TICK_BASE) - product;
    period_calc = raw;
    if (product >= 32'(TICK_BASE) || raw < 32'(TICK_MIN)) begin
      period_calc = 32'(TICK_MIN);
    end
  end

  assign wrap   = enable && (cnt == period_q - 32'd1);
  assign expiry = wrap && (gap_cnt == 32'(SPAWN_GAP - 1));

  // Search starts one past the last grant so every column gets a fair turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = 32'd0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM_COLS; k++) begin
      cand     = (32'(last_grant) + k) % NUM_COLS;
      cand_idx = COL_IDX_W'(cand);
      if (!grant_found && !col_active[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      cnt        <= 32'd0;
      period_q   <= 32'(TICK_BASE);
      gap_cnt    <= 32'd0;
      pending    <= 1'b0;
      last_grant <= COL_IDX_W'(NUM_COLS - 1);
      fall_tick  <= 1'b0;
      spawn      <= '0;
      letter_out <= '0;
    end else begin
      fall_tick <= 1'b0;
      spawn     <= '0;
      if (enable) begin
        if (wrap) begin
          cnt       <= 32'd0;
          period_q  <= period_calc;
          fall_tick <= 1'b1;
          gap_cnt   <= (gap_cnt == 32'(SPAWN_GAP - 1)) ? 32'd0 : gap_cnt + 32'd1;
        end else begin
          cnt <= cnt + 32'd1;
        end
        if (pending && grant_found) begin
          spawn      <= NUM_COLS'(1) << grant_idx;
          letter_out <= lfsr_value;
          last_grant <= grant_idx;
          pending    <= 1'b0;
        end
        // A fresh expiry re-arms the request even if the old one was just served.
        if (expiry) begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule
